// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time, byte-lane steering on stores,
// lane extraction and sign/zero extension on loads, misalignment faults.
module load_store_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        REQ,
  input  logic        REQ_WE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        FAULT,
  output logic [31:0] RDATA,
  output logic        D_MEM_CSN,
  output logic        D_MEM_WEN,
  output logic [3:0]  D_MEM_BE,
  output logic [11:0] D_MEM_ADDR,
  output logic [31:0] D_MEM_DOUT,
  input  logic [31:0] D_MEM_DI
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] LAST = 2'(MEM_LATENCY - 1);

  state_t      state, state_nxt;
  logic        we_p0;
  logic        fault_p0;
  logic [2:0]  funct3_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [31:0] rdata_p0;
  logic [1:0]  wait_cnt;
  logic        mem_active;
  logic        unused_addr;

  function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a != 2'b00;
      3'b100:  return we;
      3'b101:  return we | a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] di,
                                              input logic [1:0] a);
    logic signed [31:0] sh;
    sh = signed'(di >> {a, 3'b000});
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic [3:0] byte_lanes(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (REQ) state_nxt = is_fault(REQ_WE, REQ_FUNCT3, REQ_ADDR[1:0]) ? S_DONE : S_ACCESS;
      S_ACCESS: state_nxt = we_p0 ? S_DONE : S_WAIT;
      S_WAIT:   if (wait_cnt == LAST) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Request capture, wait counting and load result register
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      we_p0     <= 1'b0;
      fault_p0  <= 1'b0;
      funct3_p0 <= 3'b000;
      addr_p0   <= 32'h0;
      wdata_p0  <= 32'h0;
      rdata_p0  <= 32'h0;
      wait_cnt  <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && REQ) begin
        we_p0     <= REQ_WE;
        funct3_p0 <= REQ_FUNCT3;
        addr_p0   <= REQ_ADDR;
        wdata_p0  <= REQ_WDATA;
        fault_p0  <= is_fault(REQ_WE, REQ_FUNCT3, REQ_ADDR[1:0]);
      end
      if (state == S_ACCESS) wait_cnt <= 2'd0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 2'd1;
      if (state == S_WAIT && wait_cnt == LAST)
        rdata_p0 <= load_extend(funct3_p0, D_MEM_DI, addr_p0[1:0]);
    end
  end

  // Memory strobes are gated by RSTn so no write escapes while reset is held
  assign mem_active  = RSTn && (state == S_ACCESS || state == S_WAIT);
  assign D_MEM_CSN   = !mem_active;
  assign D_MEM_WEN   = !(RSTn && state == S_ACCESS && we_p0);
  assign D_MEM_BE    = mem_active ? byte_lanes(funct3_p0, addr_p0[1:0]) : 4'b0000;
  assign D_MEM_ADDR  = addr_p0[13:2];
  assign D_MEM_DOUT  = store_data(funct3_p0, wdata_p0);
  assign BUSY        = state != S_IDLE;
  assign DONE        = state == S_DONE;
  assign FAULT       = (state == S_DONE) && fault_p0;
  assign RDATA       = rdata_p0;
  assign unused_addr = &{1'b0, addr_p0[31:14]};

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (read latency 1 and 3) share the
// stimulus; a transaction-level model is compared every cycle, plus literal checks.
module tb_load_store_unit;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RSTn, REQ, REQ_WE;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic        busy[2], done[2], fault[2], csn[2], wen[2];
  logic [31:0] rdata[2], dout[2], di[2];
  logic [3:0]  be[2];
  logic [11:0] maddr[2];
  logic [31:0] mem [0:4095];

  assign di[0] = csn[0] ? 32'h0 : mem[maddr[0]];
  assign di[1] = csn[1] ? 32'h0 : mem[maddr[1]];

  load_store_unit #(.MEM_LATENCY(1)) u0 (
    .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_FUNCT3(REQ_FUNCT3),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .BUSY(busy[0]), .DONE(done[0]),
    .FAULT(fault[0]), .RDATA(rdata[0]), .D_MEM_CSN(csn[0]), .D_MEM_WEN(wen[0]),
    .D_MEM_BE(be[0]), .D_MEM_ADDR(maddr[0]), .D_MEM_DOUT(dout[0]), .D_MEM_DI(di[0]));

  load_store_unit #(.MEM_LATENCY(3)) u1 (
    .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_FUNCT3(REQ_FUNCT3),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .BUSY(busy[1]), .DONE(done[1]),
    .FAULT(fault[1]), .RDATA(rdata[1]), .D_MEM_CSN(csn[1]), .D_MEM_WEN(wen[1]),
    .D_MEM_BE(be[1]), .D_MEM_ADDR(maddr[1]), .D_MEM_DOUT(dout[1]), .D_MEM_DI(di[1]));

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic model_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int n = size_of(f3);
    if (n == 0) return 1'b1;
    if (we && f3[2]) return 1'b1;
    return (int'(addr[1:0]) % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] w,
                                             input logic [31:0] addr);
    int n = size_of(f3);
    int a = int'(addr[1:0]);
    logic [31:0] v = w >> (8 * a);
    if (n < 4) begin
      v = v & ((32'd1 << (8 * n)) - 32'd1);
      if (!f3[2] && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    end
    return v;
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] addr);
    int n = size_of(f3);
    return 4'(((1 << n) - 1) << int'(addr[1:0]));
  endfunction

  function automatic logic [31:0] model_dout(input logic [2:0] f3, input logic [31:0] wd);
    int n = size_of(f3);
    logic [31:0] o;
    for (int j = 0; j < 4; j++) o[8*j +: 8] = wd[8*(j % n) +: 8];
    return o;
  endfunction

  bit          m_act[2];
  int          m_k[2], m_len[2];
  logic        m_we[2], m_fault[2];
  logic [2:0]  m_f3[2];
  logic [31:0] m_addr[2], m_wd[2], m_rd[2];

  // m_k counts cycles since the accepting edge; m_len is the cycle DONE shows
  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (!RSTn) begin
        m_act[i] = 1'b0; m_k[i] = 0; m_rd[i] = 32'h0;
      end else if (!m_act[i]) begin
        if (REQ) begin
          m_we[i] = REQ_WE; m_f3[i] = REQ_FUNCT3; m_addr[i] = REQ_ADDR; m_wd[i] = REQ_WDATA;
          m_fault[i] = model_fault(REQ_WE, REQ_FUNCT3, REQ_ADDR);
          m_len[i] = m_fault[i] ? 1 : (REQ_WE ? 2 : 2 + lat_of(i));
          m_k[i] = 1; m_act[i] = 1'b1;
        end
      end else if (m_k[i] == m_len[i]) begin
        m_act[i] = 1'b0; m_k[i] = 0;
      end else begin
        m_k[i]++;
        if (m_k[i] == m_len[i] && !m_we[i] && !m_fault[i])
          m_rd[i] = model_load(m_f3[i], mem[m_addr[i][13:2]], m_addr[i]);
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        logic memph, edone;
        memph = m_act[i] && !m_fault[i] && m_k[i] < m_len[i] && RSTn;
        edone = m_act[i] && m_k[i] == m_len[i];
        chk($sformatf("u%0d.BUSY", i), 32'(busy[i]), 32'(m_act[i]));
        chk($sformatf("u%0d.DONE", i), 32'(done[i]), 32'(edone));
        chk($sformatf("u%0d.FAULT", i), 32'(fault[i]), 32'(edone && m_fault[i]));
        chk($sformatf("u%0d.CSN", i), 32'(csn[i]), 32'(!memph));
        chk($sformatf("u%0d.WEN", i), 32'(wen[i]), 32'(!(memph && m_we[i] && m_k[i] == 1)));
        chk($sformatf("u%0d.BE", i), 32'(be[i]), memph ? 32'(model_mask(m_f3[i], m_addr[i])) : 32'h0);
        chk($sformatf("u%0d.RDATA", i), rdata[i], m_rd[i]);
        if (memph) chk($sformatf("u%0d.ADDR", i), 32'(maddr[i]), 32'(m_addr[i][13:2]));
        if (memph && m_we[i]) chk($sformatf("u%0d.DOUT", i), dout[i], model_dout(m_f3[i], m_wd[i]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int          lat[2], csnlo[2], wenlo[2], flt[2], ndone[2];
  logic [31:0] rd[2], do1[2];
  logic [3:0]  be1[2];
  logic [11:0] ad1[2];

  task automatic observe(input int cycles);
    for (int i = 0; i < 2; i++) begin
      lat[i] = 0; csnlo[i] = 0; wenlo[i] = 0; flt[i] = 0; ndone[i] = 0;
    end
    for (int k = 1; k <= cycles; k++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        if (done[i]) ndone[i]++;
        if (done[i] && lat[i] == 0) begin lat[i] = k; rd[i] = rdata[i]; flt[i] = int'(fault[i]); end
        if (!csn[i]) csnlo[i]++;
        if (!wen[i]) wenlo[i]++;
        if (k == 1) begin be1[i] = be[i]; ad1[i] = maddr[i]; do1[i] = dout[i]; end
      end
      @(posedge CLK); #2;
    end
  endtask

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd);
    REQ = 1'b1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = addr; REQ_WDATA = wd;
    @(posedge CLK); #2;
    REQ = 1'b0;
    observe(8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = (i * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
    mem[12'h040] = 32'h80FF_1234;
    mem[12'h002] = 32'h8001_0000;
    mem[12'h041] = 32'h1357_9BDF;
    mem[12'h010] = 32'hC0DE_7F01;
    RSTn = 1'b0; REQ = 1'b0; REQ_WE = 1'b0; REQ_FUNCT3 = 3'b000;
    REQ_ADDR = 32'h0; REQ_WDATA = 32'h0;
    @(posedge CLK); #2;
    cmp_en = 1'b1;
    @(negedge CLK);
    chk("reset.BUSY", 32'(busy[0]), 32'h0);
    chk("reset.DONE", 32'(done[0]), 32'h0);
    chk("reset.RDATA", rdata[0], 32'h0);
    chk("reset.CSN", 32'(csn[0]), 32'h1);
    @(posedge CLK); #2;
    RSTn = 1'b1;

    xact(1'b0, 3'b000, 32'h103, 32'h0);
    chk("lb.lat0", 32'(lat[0]), 32'd3);
    chk("lb.lat1", 32'(lat[1]), 32'd5);
    chk("lb.be", 32'(be1[0]), 32'h8);
    chk("lb.addr", 32'(ad1[0]), 32'h040);
    chk("lb.rdata0", rd[0], 32'hFFFF_FF80);
    chk("lb.rdata1", rd[1], 32'hFFFF_FF80);

    xact(1'b1, 3'b001, 32'h202, 32'h1234_ABCD);
    chk("sh.lat0", 32'(lat[0]), 32'd2);
    chk("sh.wenlo", 32'(wenlo[0]), 32'd1);
    chk("sh.be", 32'(be1[0]), 32'hC);
    chk("sh.dout", do1[0], 32'hABCD_ABCD);

    xact(1'b0, 3'b010, 32'h006, 32'h0);
    chk("lw_mis.lat", 32'(lat[0]), 32'd1);
    chk("lw_mis.fault", 32'(flt[0]), 32'd1);
    chk("lw_mis.csnlo", 32'(csnlo[0]), 32'd0);
    chk("lw_mis.rdata", rd[0], 32'hFFFF_FF80);

    xact(1'b0, 3'b101, 32'h00A, 32'h0);
    chk("lhu.lat1", 32'(lat[1]), 32'd5);
    chk("lhu.rdata1", rd[1], 32'h0000_8001);
    chk("lhu.csnlo1", 32'(csnlo[1]), 32'd4);

    xact(1'b1, 3'b101, 32'h010, 32'h0);
    chk("st_f3_1xx.fault", 32'(flt[0]), 32'd1);
    xact(1'b0, 3'b001, 32'h042, 32'h0);
    chk("lh.rdata0", rd[0], 32'hFFFF_C0DE);
    xact(1'b0, 3'b100, 32'h101, 32'h0);
    xact(1'b1, 3'b000, 32'h033, 32'hDEAD_BEEF);
    xact(1'b1, 3'b010, 32'h100, 32'h0BAD_F00D);
    xact(1'b0, 3'b011, 32'h000, 32'h0);
    xact(1'b0, 3'b001, 32'h005, 32'h0);
    xact(1'b1, 3'b010, 32'h102, 32'h1111_2222);
    xact(1'b0, 3'b010, 32'h104, 32'h0);

    // reset while a store sits in ACCESS
    REQ = 1'b1; REQ_WE = 1'b1; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h300; REQ_WDATA = 32'hFFFF_0000;
    @(posedge CLK); #2;
    REQ = 1'b0; RSTn = 1'b0;
    @(negedge CLK);
    chk("rst_store.wen0", 32'(wen[0]), 32'h1);
    chk("rst_store.wen1", 32'(wen[1]), 32'h1);
    @(posedge CLK); #2;
    RSTn = 1'b1;
    observe(6);
    chk("rst_store.ndone0", 32'(ndone[0]), 32'd0);
    chk("rst_store.ndone1", 32'(ndone[1]), 32'd0);
    chk("rst_store.rdata", rdata[0], 32'h0);

    // REQ kept high while busy, with the request fields changing underneath
    REQ = 1'b1; REQ_WE = 1'b0; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h104;
    @(posedge CLK); #2;
    REQ_ADDR = 32'h008; REQ_FUNCT3 = 3'b000;
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    @(posedge CLK); #2;
    REQ = 1'b0;
    observe(8);
    chk("busy_req.rdata0", rdata[0], 32'h1357_9BDF);
    chk("busy_req.rdata1", rdata[1], 32'h1357_9BDF);

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, meaning D-memory read latency in cycles (legal range 1..4).
REQ-002 SHALL have port CLK  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port RSTn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port REQ  in  1  access request, sampled only in IDLE.
REQ-005 SHALL have port REQ_WE  in  1  1 = store, 0 = load.
REQ-006 SHALL have port REQ_FUNCT3  in  3  RV32I width/sign code (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
REQ-007 SHALL have port REQ_ADDR  in  32  byte address (ALU result).
REQ-008 SHALL have port REQ_WDATA  in  32  store data (rs2).
REQ-009 SHALL have ports BUSY  out  1  (state != IDLE); DONE  out  1  (one-cycle completion pulse); FAULT  out  1  (misaligned or unsupported access, valid with DONE).
REQ-010 SHALL have port RDATA  out  32  aligned, extended load result.
REQ-011 SHALL have ports D_MEM_CSN  out  1  (active-low select); D_MEM_WEN  out  1  (active-low write); D_MEM_BE  out  4  (byte lanes); D_MEM_ADDR  out  12  (word address = addr[13:2]); D_MEM_DOUT  out  32; D_MEM_DI  in  32.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, WAIT, DONE.
REQ-013 SHALL, in IDLE with REQ=1, capture REQ_WE/FUNCT3/ADDR/WDATA and go to ACCESS, or go directly to DONE with FAULT=1 if the access is faulting.
REQ-014 SHALL fault on: halfword with addr[0]=1; word with addr[1:0]!=00; funct3 011/110/111; store with funct3 1xx. A faulting access makes no memory access.
REQ-015 SHALL ignore REQ in every state other than IDLE; captured fields stay stable until return to IDLE.
REQ-016 SHALL go ACCESS->DONE for stores and ACCESS->WAIT for loads; WAIT lasts exactly MEM_LATENCY cycles, then DONE; DONE->IDLE unconditionally.
REQ-017 SHALL drive D_MEM_CSN=0 in ACCESS and WAIT and 1 otherwise; D_MEM_WEN=0 only in ACCESS of a store.
REQ-018 SHALL hold D_MEM_ADDR and D_MEM_BE stable through ACCESS and WAIT; D_MEM_BE=0000 while CSN=1.
REQ-019 SHALL set the byte-lane mask as: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-020 SHALL drive D_MEM_DOUT as: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-021 SHALL, for loads, register RDATA on the final WAIT edge from D_MEM_DI >> (8*addr[1:0]): LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged.
REQ-022 SHALL hold RDATA until the next successful load completes; stores and faults leave it unchanged.
REQ-023 SHALL keep DONE high exactly one cycle (the DONE state) and FAULT high only in that cycle.
REQ-024 SHALL have the following latency from the accepting edge to the first DONE-high cycle: fault 1 cycle; store 2 cycles; load 2+MEM_LATENCY cycles.
REQ-025 SHALL, when the accepting edge is followed by REQ still high in DONE, not start a new access until IDLE is re-entered.

Reset
REQ-026 SHALL, on a rising edge with RSTn=0, enter IDLE and clear BUSY, DONE, FAULT, RDATA (0), and all captured fields.
REQ-027 SHALL combinationally force D_MEM_CSN=1, D_MEM_WEN=1, D_MEM_BE=0000 while RSTn=0, so no write is issued.
REQ-028 SHALL abandon any access in progress on reset, with no DONE pulse for it.

Verification
REQ-029 SHALL cover: LB at addr 0x103, memory word 0x80FF_1234 -> BE=1000, D_MEM_ADDR=0x040, RDATA=0xFFFF_FF80, DONE in cycle 3 (MEM_LATENCY=1).
REQ-030 SHALL cover: SH at addr 0x202, wdata 0x1234_ABCD -> one ACCESS cycle with WEN=0, BE=1100, DOUT=0xABCD_ABCD, DONE in cycle 2.
REQ-031 SHALL cover: LW at addr 0x006 -> DONE+FAULT in cycle 1, CSN stays 1, RDATA unchanged.
REQ-032 SHALL cover: LHU at addr 0x00A, word 0x8001_0000, MEM_LATENCY=3 -> RDATA=0x0000_8001, DONE in cycle 5, CSN low for 4 cycles.
REQ-033 SHALL cover: RSTn=0 during ACCESS of a store -> WEN never low in that cycle, IDLE next edge, no DONE; REQ asserted while BUSY -> ignored.
